// File: rtl/helix_thought_unpacker.sv
// Thought-word unpacker: splits one wide thought word into narrow context beats.
// Supports a single beat, MSB-first, LSB-first, or LSB-first followed by an XOR checksum beat.
module helix_thought_unpacker #(
  parameter int CONTEXT_W = 32,
  parameter int THOUGHT_W = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 thought_valid,
  output logic                 thought_ready,
  input  logic [THOUGHT_W-1:0] thought_data,
  input  logic [1:0]           precision_mode,
  output logic                 ctx_valid,
  input  logic                 ctx_ready,
  output logic [CONTEXT_W-1:0] ctx_data,
  output logic                 ctx_last,
  output logic                 busy
);

  localparam int N = THOUGHT_W / CONTEXT_W;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_UP     = 2'b10;
  localparam logic [1:0] MODE_CSUM   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EMIT  = 2'b01,
    ST_CHECK = 2'b10
  } state_t;

  state_t                 state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [THOUGHT_W-1:0]   thought_r, thought_s;
  logic [1:0]             mode_r, mode_s;
  logic                   ctx_valid_r, ctx_valid_s;
  logic [CONTEXT_W-1:0]   ctx_data_r, ctx_data_s;
  logic                   ctx_last_r, ctx_last_s;
  logic                   busy_r, busy_s;
  logic                   thought_ready_s;
  logic                   accept_s;
  logic                   xfer_s;

  // Beat index idx maps to a slice; in the MSB-first mode the order is reversed.
  function automatic logic [CONTEXT_W-1:0] pick_slice(
    input logic [THOUGHT_W-1:0] word,
    input logic [1:0]           mode,
    input logic [CNT_W-1:0]     idx
  );
    logic [CNT_W-1:0] k;
    if (mode == MODE_DOWN) begin
      k = LAST_IDX - idx;
    end else begin
      k = idx;
    end
    return word[int'(k)*CONTEXT_W +: CONTEXT_W];
  endfunction

  function automatic logic [CONTEXT_W-1:0] xor_fold(input logic [THOUGHT_W-1:0] word);
    logic [CONTEXT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc ^ word[i*CONTEXT_W +: CONTEXT_W];
    end
    return acc;
  endfunction

  // The checksum mode never flags last on a slice beat; the checksum beat carries it.
  function automatic logic slice_is_last(input logic [1:0] mode, input logic [CNT_W-1:0] idx);
    logic flag;
    case (mode)
      MODE_SINGLE: flag = 1'b1;
      MODE_DOWN:   flag = (idx == LAST_IDX);
      MODE_UP:     flag = (idx == LAST_IDX);
      default:     flag = 1'b0;
    endcase
    return flag;
  endfunction

  assign xfer_s          = ctx_valid_r & ctx_ready;
  assign thought_ready_s = rst_n & ((state_r == ST_IDLE) | (xfer_s & ctx_last_r));
  assign accept_s        = thought_valid & thought_ready_s;

  assign thought_ready = thought_ready_s;
  assign ctx_valid     = ctx_valid_r;
  assign ctx_data      = ctx_data_r;
  assign ctx_last      = ctx_last_r;
  assign busy          = busy_r;

  // Next-state and next-output computation; acceptance wins over plain beat progress.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    thought_s   = thought_r;
    mode_s      = mode_r;
    ctx_valid_s = ctx_valid_r;
    ctx_data_s  = ctx_data_r;
    ctx_last_s  = ctx_last_r;
    busy_s      = busy_r;
    if (accept_s) begin
      state_s     = ST_EMIT;
      cnt_s       = '0;
      thought_s   = thought_data;
      mode_s      = precision_mode;
      ctx_valid_s = 1'b1;
      ctx_data_s  = pick_slice(thought_data, precision_mode, '0);
      ctx_last_s  = slice_is_last(precision_mode, '0);
      busy_s      = 1'b1;
    end else if (xfer_s) begin
      if (ctx_last_r) begin
        state_s     = ST_IDLE;
        cnt_s       = '0;
        ctx_valid_s = 1'b0;
        ctx_data_s  = '0;
        ctx_last_s  = 1'b0;
        busy_s      = 1'b0;
      end else begin
        case (state_r)
          ST_EMIT: begin
            if ((mode_r == MODE_CSUM) && (cnt_r == LAST_IDX)) begin
              state_s    = ST_CHECK;
              ctx_data_s = xor_fold(thought_r);
              ctx_last_s = 1'b1;
            end else begin
              cnt_s      = cnt_r + CNT_W'(1);
              ctx_data_s = pick_slice(thought_r, mode_r, cnt_s);
              ctx_last_s = slice_is_last(mode_r, cnt_s);
            end
          end
          default: begin
            // A non-final beat outside EMIT cannot occur; fall back to idle.
            state_s     = ST_IDLE;
            cnt_s       = '0;
            ctx_valid_s = 1'b0;
            ctx_data_s  = '0;
            ctx_last_s  = 1'b0;
            busy_s      = 1'b0;
          end
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // State and registered outputs; reset discards any partially emitted thought.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      thought_r   <= '0;
      mode_r      <= 2'b00;
      ctx_valid_r <= 1'b0;
      ctx_data_r  <= '0;
      ctx_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      thought_r   <= thought_s;
      mode_r      <= mode_s;
      ctx_valid_r <= ctx_valid_s;
      ctx_data_r  <= ctx_data_s;
      ctx_last_r  <= ctx_last_s;
      busy_r      <= busy_s;
    end
  end

endmodule

// File: tb/tb_helix_thought_unpacker.sv
// Bench for helix_thought_unpacker: queue-based beat model checked every cycle,
// plus directed sequences compared against hand-written beat lists.
module tb_helix_thought_unpacker;

  localparam int CW = 32;
  localparam int TW = 128;
  localparam logic [TW-1:0] T  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [TW-1:0] T2 = 128'h88888888_77777777_66666666_55555555;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          thought_valid = 1'b0;
  logic          thought_ready;
  logic [TW-1:0] thought_data = '0;
  logic [1:0]    precision_mode = 2'b00;
  logic          ctx_valid;
  logic          ctx_ready = 1'b0;
  logic [CW-1:0] ctx_data;
  logic          ctx_last;
  logic          busy;

  helix_thought_unpacker #(.CONTEXT_W(CW), .THOUGHT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .thought_valid(thought_valid), .thought_ready(thought_ready),
    .thought_data(thought_data), .precision_mode(precision_mode),
    .ctx_valid(ctx_valid), .ctx_ready(ctx_ready),
    .ctx_data(ctx_data), .ctx_last(ctx_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [CW-1:0] data; logic last;} beat_t;
  beat_t         exp_q[$];
  logic [CW-1:0] got_q[$];
  logic          got_last[$];
  int            got_cyc[$];
  logic          stall = 1'b0;
  logic [CW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [CW-1:0] slice_of(input logic [TW-1:0] t, input int k);
    logic [TW-1:0] s;
    s = t >> (CW * k);
    return s[CW-1:0];
  endfunction

  // Expected beat list for one accepted thought, straight from the mode rules.
  function automatic void model_push(input logic [TW-1:0] t, input logic [1:0] m);
    beat_t b;
    logic [CW-1:0] x;
    x = '0;
    case (m)
      2'b00: begin b.data = slice_of(t, 0); b.last = 1'b1; exp_q.push_back(b); end
      2'b01: for (int k = 3; k >= 0; k--) begin b.data = slice_of(t, k); b.last = (k == 0); exp_q.push_back(b); end
      2'b10: for (int k = 0; k < 4; k++) begin b.data = slice_of(t, k); b.last = (k == 3); exp_q.push_back(b); end
      default: begin
        for (int k = 0; k < 4; k++) begin
          b.data = slice_of(t, k); b.last = 1'b0; exp_q.push_back(b); x = x ^ b.data;
        end
        b.data = x; b.last = 1'b1; exp_q.push_back(b);
      end
    endcase
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_thought_ready", thought_ready, 0);
      chk("rst_ctx_valid", ctx_valid, 0);
      chk("rst_ctx_data", ctx_data, 0);
      chk("rst_ctx_last", ctx_last, 0);
      chk("rst_busy", busy, 0);
      exp_q.delete();
      stall = 1'b0;
    end else begin
      chk("busy", busy, exp_q.size() > 0);
      chk("ctx_valid", ctx_valid, exp_q.size() > 0);
      chk("thought_ready", thought_ready, (exp_q.size() == 0) || (exp_q.size() == 1 && ctx_ready));
      if (stall) begin
        chk("stall_data", ctx_data, prev_d);
        chk("stall_last", ctx_last, prev_l);
      end
      if (ctx_valid && exp_q.size() > 0) begin
        chk("beat_data", ctx_data, exp_q[0].data);
        chk("beat_last", ctx_last, exp_q[0].last);
      end
      if (ctx_valid && ctx_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got_q.push_back(ctx_data);
        got_last.push_back(ctx_last);
        got_cyc.push_back(cyc);
      end
      stall  = ctx_valid && !ctx_ready;
      prev_d = ctx_data;
      prev_l = ctx_last;
      if (thought_valid && thought_ready) model_push(thought_data, precision_mode);
    end
  end

  task automatic clear_log();
    got_q.delete(); got_last.delete(); got_cyc.delete();
  endtask

  task automatic wait_accept(output int acc_cyc);
    int n = 0;
    @(negedge clk);
    while (!thought_ready && n < 50) begin @(negedge clk); n++; end
    if (!thought_ready) chk("accept_timeout", 0, 1);
    acc_cyc = cyc;
  endtask

  task automatic send(input logic [TW-1:0] t, input logic [1:0] m, output int acc_cyc);
    thought_data = t; precision_mode = m; thought_valid = 1'b1;
    wait_accept(acc_cyc);
    @(posedge clk); #2;
    thought_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((busy || ctx_valid) && n < 100) begin @(negedge clk); n++; end
    if (busy || ctx_valid) chk("drain_timeout", 0, 1);
    @(posedge clk); #2;
  endtask

  function automatic void check_got(input string name, input logic [CW-1:0] e[$]);
    chk({name, "_count"}, got_q.size(), e.size());
    for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
      chk({name, "_data"}, got_q[i], e[i]);
      chk({name, "_last"}, got_last[i], (i == e.size() - 1) || (i == 3 && e.size() == 8));
    end
  endfunction

  function automatic void check_consecutive(input string name);
    for (int i = 1; i < got_cyc.size(); i++) chk(name, got_cyc[i] - got_cyc[i-1], 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] e[$];
    int a1, a2, n;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", thought_ready, 1);
    @(posedge clk); #2;
    ctx_ready = 1'b1;

    // Mode 10: LSB-first, latency one cycle, back-to-back beats
    clear_log();
    send(T, 2'b10, a1);
    drain();
    e = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    check_got("mode10", e);
    check_consecutive("mode10_gap");
    if (got_cyc.size() > 0) chk("mode10_latency", got_cyc[0] - a1, 1);

    // Mode 01: MSB-first
    clear_log();
    send(T, 2'b01, a1);
    drain();
    e = '{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    check_got("mode01", e);

    // Mode 00: single beat
    clear_log();
    send(T, 2'b00, a1);
    drain();
    e = '{32'h11111111};
    check_got("mode00", e);

    // Mode 11: slices then XOR checksum
    clear_log();
    send(T, 2'b11, a1);
    drain();
    e = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h44444444};
    check_got("mode11", e);

    // Mode 10 with stalls and a mode flip while busy
    clear_log();
    fork
      send(T, 2'b10, a1);
      begin
        for (int i = 0; i < 16; i++) begin
          @(posedge clk); #2;
          ctx_ready = (i % 4 == 0) || (i % 4 == 3);
          if (i == 3) precision_mode = 2'b00;
        end
      end
    join
    ctx_ready = 1'b1;
    drain();
    e = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    check_got("stall", e);

    // Two thoughts back to back with thought_valid held high
    clear_log();
    thought_data = T; precision_mode = 2'b10; thought_valid = 1'b1;
    wait_accept(a1);
    @(posedge clk); #2;
    thought_data = T2;
    wait_accept(a2);
    @(posedge clk); #2;
    thought_valid = 1'b0;
    drain();
    e = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
          32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    check_got("b2b", e);
    check_consecutive("b2b_gap");
    if (got_cyc.size() == 8) chk("b2b_second_accept", a2, got_cyc[3]);

    // Reset in the middle of a thought
    clear_log();
    send(T, 2'b10, a1);
    n = 0;
    @(negedge clk);
    while (got_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
    chk("mid_reset_reach", got_q.size(), 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", ctx_valid, 0);
    chk("mid_reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_log();
    send(T, 2'b10, a1);
    drain();
    e = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    check_got("after_reset", e);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
